// File: rtl/fifo_wptr_ctrl.sv
// Purpose: write-side pointer/flag controller of a dual-clock FIFO (wclk domain): RAM write port, Gray wptr export, full/almost-full/level/overflow.
// Latency: RAM write registered 1 cycle after accept; wptr 2 cycles after accept; flags/level registered, reflecting the same edge's accept and wq2_rptr.
// Backpressure: wfull blocks accepts; writes attempted while full are dropped and set the sticky wovf flag.
module fifo_wptr_ctrl #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          wclk,
    input  logic          wrst,
    input  logic          wen,
    input  logic [DW-1:0] wdata,
    input  logic [AW:0]   wq2_rptr,
    input  logic [AW:0]   afull_thresh,
    input  logic          ovf_clr,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_wen,
    output logic [AW:0]   wptr,
    output logic          wfull,
    output logic          wafull,
    output logic [AW:0]   wlevel,
    output logic          wovf
);

    // Pointer state: binary count, its Gray image, and the export stage.
    logic [AW:0]   wbin_q, wbin_d;
    logic [AW:0]   gray_q, gray_d;
    logic [AW:0]   wptr_q;

    // Registered RAM write port.
    logic          mem_wen_q;
    logic [AW-1:0] mem_waddr_q;
    logic [DW-1:0] mem_wdata_q;

    // Registered status flags.
    logic          wfull_q, wfull_d;
    logic          wafull_q, wafull_d;
    logic [AW:0]   wlevel_q, wlevel_d;
    logic          wovf_q, wovf_d;

    // Combinational helpers.
    logic          acc;
    logic [AW:0]   rbin;
    logic [AW:0]   full_cmp;

    // Accept decision and next pointer values (binary and Gray).
    always_comb begin
        acc    = wen & ~wfull_q;
        wbin_d = wbin_q + {{AW{1'b0}}, acc};
        gray_d = (wbin_d >> 1) ^ wbin_d;
    end

    // Synchronised read pointer from Gray back to binary: each bit is the XOR of itself and all higher bits.
    always_comb begin
        rbin     = '0;
        rbin[AW] = wq2_rptr[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ wq2_rptr[i];
        end
    end

    // Next-state flags: full when the next Gray write pointer is one lap ahead of the read pointer.
    always_comb begin
        full_cmp = {~wq2_rptr[AW:AW-1], wq2_rptr[AW-2:0]};
        wfull_d  = (gray_d == full_cmp);
        wlevel_d = wbin_d - rbin;
        wafull_d = (wlevel_d >= afull_thresh);
        wovf_d   = wovf_q;
        if (wen & wfull_q) begin
            wovf_d = 1'b1;
        end else if (ovf_clr) begin
            wovf_d = 1'b0;
        end
    end

    // Pointer registers; wptr lags the internal Gray pointer by one stage so it moves after the RAM write lands.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin_q <= '0;
            gray_q <= '0;
            wptr_q <= '0;
        end else begin
            wbin_q <= wbin_d;
            gray_q <= gray_d;
            wptr_q <= gray_q;
        end
    end

    // RAM write port: enable pulses per accept, address/data hold their last written values otherwise.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            mem_wen_q   <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_wen_q <= acc;
            if (acc) begin
                mem_waddr_q <= wbin_q[AW-1:0];
                mem_wdata_q <= wdata;
            end
        end
    end

    // Status flags: full, almost-full, level and sticky overflow all update on the same edge.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wlevel_q <= '0;
            wovf_q   <= 1'b0;
        end else begin
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wlevel_q <= wlevel_d;
            wovf_q   <= wovf_d;
        end
    end

    assign mem_wen   = mem_wen_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wdata = mem_wdata_q;
    assign wptr      = wptr_q;
    assign wfull     = wfull_q;
    assign wafull    = wafull_q;
    assign wlevel    = wlevel_q;
    assign wovf      = wovf_q;

endmodule
